// File: rtl/xe_prefix_pair_seq_pkg.sv
// Shared constants and types for the 8Exx/CExx prefix pair sequencer.
// Prefix byte values and sequencer state encoding.
package xe_prefix_pair_seq_pkg;

    localparam logic [7:0] PFX_8E = 8'h8E;
    localparam logic [7:0] PFX_CE = 8'hCE;

    typedef enum logic {
        XSEQ_IDLE = 1'b0,
        XSEQ_PFX  = 1'b1
    } xseq_state_t;

endpackage

// File: rtl/xe_prefix_pair_seq_pfx_detect.sv
// Combinational prefix classifier for one 16-bit instruction word.
// Shared with the decoder integration.
module xe_pfx_detect
    import xe_prefix_pair_seq_pkg::*;
#(
    parameter int ALLOW_CE = 1
) (
    input  logic [15:0] word,
    output logic        isPfx,
    output logic        isXE,
    output logic        isCE
);

    assign isXE  = (word[15:8] == PFX_8E);
    assign isCE  = (ALLOW_CE != 0) && (word[15:8] == PFX_CE);
    assign isPfx = isXE || isCE;

endmodule

// File: rtl/xe_prefix_pair_seq.sv
// Pairs 8Exx/CExx prefix words with their opcode word and presents
// one registered {opcode, prefix} op per instruction to decode.
module xe_prefix_pair_seq
    import xe_prefix_pair_seq_pkg::*;
#(
    parameter int PCW      = 32,
    parameter int ALLOW_CE = 1
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           iFlush,
    input  logic           iWordValid,
    input  logic [15:0]    iWord,
    input  logic [PCW-1:0] iWordPc,
    output logic           oWordReady,
    output logic           oOpValid,
    input  logic           iOpReady,
    output logic [31:0]    oOpWord,
    output logic [PCW-1:0] oOpPc,
    output logic           oOpXE,
    output logic           oOpCE,
    output logic           oOpFault,
    output logic [7:0]     oFaultCnt
);

    xseq_state_t    state, state_n;
    logic [15:0]    pfx_word, pfx_word_n;
    logic [PCW-1:0] pfx_pc, pfx_pc_n;
    logic           pfx_xe, pfx_xe_n;
    logic           pfx_ce, pfx_ce_n;

    logic           valid_n;
    logic [31:0]    op_word_n;
    logic [PCW-1:0] op_pc_n;
    logic           xe_n, ce_n, fault_n;
    logic           fault_load;

    logic           in_pfx, in_xe, in_ce;
    logic           accept;

    xe_pfx_detect #(.ALLOW_CE(ALLOW_CE)) u_detect (
        .word  (iWord),
        .isPfx (in_pfx),
        .isXE  (in_xe),
        .isCE  (in_ce)
    );

    // Only take a word that can be retired into the slot this cycle.
    assign oWordReady = !iFlush && (!oOpValid || iOpReady);
    assign accept     = iWordValid && oWordReady;

    always_comb begin
        state_n    = state;
        pfx_word_n = pfx_word;
        pfx_pc_n   = pfx_pc;
        pfx_xe_n   = pfx_xe;
        pfx_ce_n   = pfx_ce;
        valid_n    = oOpValid && !iOpReady;
        op_word_n  = oOpWord;
        op_pc_n    = oOpPc;
        xe_n       = oOpXE;
        ce_n       = oOpCE;
        fault_n    = oOpFault;
        fault_load = 1'b0;
        if (iFlush) begin
            state_n = XSEQ_IDLE;
            valid_n = 1'b0;
        end else if (accept) begin
            unique case (state)
                XSEQ_IDLE: begin
                    if (in_pfx) begin
                        pfx_word_n = iWord;
                        pfx_pc_n   = iWordPc;
                        pfx_xe_n   = in_xe;
                        pfx_ce_n   = in_ce;
                        state_n    = XSEQ_PFX;
                    end else begin
                        valid_n   = 1'b1;
                        op_word_n = {iWord, 16'h0};
                        op_pc_n   = iWordPc;
                        xe_n      = 1'b0;
                        ce_n      = 1'b0;
                        fault_n   = 1'b0;
                    end
                end
                XSEQ_PFX: begin
                    valid_n = 1'b1;
                    op_pc_n = pfx_pc;
                    if (in_pfx) begin
                        // Orphaned prefix: emit it as a fault, hold the new one.
                        op_word_n  = {16'h0, pfx_word};
                        xe_n       = 1'b0;
                        ce_n       = 1'b0;
                        fault_n    = 1'b1;
                        fault_load = 1'b1;
                        pfx_word_n = iWord;
                        pfx_pc_n   = iWordPc;
                        pfx_xe_n   = in_xe;
                        pfx_ce_n   = in_ce;
                    end else begin
                        op_word_n = {iWord, pfx_word};
                        xe_n      = pfx_xe;
                        ce_n      = pfx_ce;
                        fault_n   = 1'b0;
                        state_n   = XSEQ_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= XSEQ_IDLE;
            pfx_word <= '0;
            pfx_pc   <= '0;
            pfx_xe   <= 1'b0;
            pfx_ce   <= 1'b0;
            oOpValid <= 1'b0;
            oOpWord  <= '0;
            oOpPc    <= '0;
            oOpXE    <= 1'b0;
            oOpCE    <= 1'b0;
            oOpFault <= 1'b0;
        end else begin
            state    <= state_n;
            pfx_word <= pfx_word_n;
            pfx_pc   <= pfx_pc_n;
            pfx_xe   <= pfx_xe_n;
            pfx_ce   <= pfx_ce_n;
            oOpValid <= valid_n;
            oOpWord  <= op_word_n;
            oOpPc    <= op_pc_n;
            oOpXE    <= xe_n;
            oOpCE    <= ce_n;
            oOpFault <= fault_n;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            oFaultCnt <= '0;
        end else if (fault_load && oFaultCnt != 8'hFF) begin
            oFaultCnt <= oFaultCnt + 8'd1;
        end
    end

endmodule
